// File: rtl/ea_pkg.sv
// Shared defaults and helpers for the EX-stage effective-address offset pipeline.
// Contents:
//   *_DEF localparams : default widths/sizes used by ea_offset_pipe and hlen_regfile
//   tid_w()           : thread-id width for a given thread count (never below 1)
package ea_pkg;

    localparam int unsigned DATA_W_DEF     = 64;
    localparam int unsigned HLEN_W_DEF     = 8;
    localparam int unsigned HLEN_SHIFT_DEF = 3;
    localparam int unsigned NUM_THR_DEF    = 4;
    localparam int unsigned MEM_DEPTH_DEF  = 2048;
    localparam int unsigned CNT_W_DEF      = 16;

    // A single-thread build still carries a 1-bit thread id so ports never collapse.
    function automatic int unsigned tid_w(input int unsigned num_thr);
        return (num_thr > 1) ? int'($clog2(num_thr)) : 1;
    endfunction

endpackage

// File: rtl/ea_offset_pipe_hlen_regfile.sv
// Per-thread packet header length (HLEN) register file.
// Ports:
//   clk, reset       : clock, synchronous active-high reset (clears every HLEN)
//   wr_en            : write strobe
//   wr_thread        : thread whose HLEN is written
//   wr_data          : new HLEN value, in words
//   rd_thread        : thread whose HLEN is read
//   rd_data_c        : combinational read data, write-first on a same-thread write
module hlen_regfile
    import ea_pkg::*;
#(
    parameter int unsigned HLEN_W  = HLEN_W_DEF,
    parameter int unsigned NUM_THR = NUM_THR_DEF,
    localparam int unsigned TID_W  = tid_w(NUM_THR)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [TID_W-1:0]  wr_thread,
    input  logic [HLEN_W-1:0] wr_data,
    input  logic [TID_W-1:0]  rd_thread,
    output logic [HLEN_W-1:0] rd_data_c
);

    logic [HLEN_W-1:0] regs_q [NUM_THR];
    logic [HLEN_W-1:0] regs_d [NUM_THR];
    logic              wr_in_range_c;

    // Next register contents; ids beyond NUM_THR-1 match no entry and are dropped.
    always_comb begin
        regs_d        = regs_q;
        wr_in_range_c = 1'b0;
        for (int unsigned t = 0; t < NUM_THR; t++) begin
            if (wr_thread == TID_W'(t)) begin
                wr_in_range_c = 1'b1;
                if (wr_en) begin
                    regs_d[t] = wr_data;
                end
            end
        end
    end

    // Async read with write-first bypass so a same-cycle update is seen immediately.
    always_comb begin
        rd_data_c = '0;
        for (int unsigned t = 0; t < NUM_THR; t++) begin
            if (rd_thread == TID_W'(t)) begin
                rd_data_c = regs_q[t];
            end
        end
        if (wr_en && wr_in_range_c && (wr_thread == rd_thread)) begin
            rd_data_c = wr_data;
        end
    end

    // Register storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

endmodule

// File: rtl/ea_offset_pipe.sv
// Registered EX-stage ALU-src operand select for NUM_THR hardware threads.
// Loads/stores get the immediate offset plus the thread's header length in bytes;
// every other op passes the offset through. One valid/ready register stage.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   flush               : drop the held result and any op accepted this cycle
//   in_valid/in_ready   : EX-side handshake (in_ready = !out_valid | out_ready)
//   in_thread           : thread id of the EX op
//   in_lw, in_sw        : op is a load / store (either one makes it a memory op)
//   in_offset           : sign-extended immediate offset
//   hlen_wr_en/_thread/_data : HLEN register write port (words)
//   out_valid/out_ready : ALU-side handshake
//   out_operand         : ALU-src operand
//   out_is_mem          : operand was HLEN-adjusted
//   out_oob             : memory op whose operand is at or past MEM_DEPTH
//   mem_op_count        : saturating count of accepted, unflushed memory ops
module ea_offset_pipe
    import ea_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned HLEN_W     = HLEN_W_DEF,
    parameter int unsigned HLEN_SHIFT = HLEN_SHIFT_DEF,
    parameter int unsigned NUM_THR    = NUM_THR_DEF,
    parameter int unsigned MEM_DEPTH  = MEM_DEPTH_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF,
    localparam int unsigned TID_W     = tid_w(NUM_THR)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [TID_W-1:0]  in_thread,
    input  logic              in_lw,
    input  logic              in_sw,
    input  logic [DATA_W-1:0] in_offset,
    input  logic              hlen_wr_en,
    input  logic [TID_W-1:0]  hlen_wr_thread,
    input  logic [HLEN_W-1:0] hlen_wr_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_operand,
    output logic              out_is_mem,
    output logic              out_oob,
    output logic [CNT_W-1:0]  mem_op_count
);

    localparam logic [DATA_W-1:0] MEM_LIMIT = DATA_W'(MEM_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [HLEN_W-1:0] hlen_c;
    logic              mem_c;
    logic              accept_c;
    logic [DATA_W-1:0] hlen_bytes_c;
    logic [DATA_W-1:0] operand_c;
    logic              oob_c;

    logic              out_valid_q,   out_valid_d;
    logic [DATA_W-1:0] out_operand_q, out_operand_d;
    logic              out_is_mem_q,  out_is_mem_d;
    logic              out_oob_q,     out_oob_d;
    logic [CNT_W-1:0]  cnt_q,         cnt_d;

    // Per-thread HLEN storage; writes proceed regardless of stall or flush.
    hlen_regfile #(
        .HLEN_W  (HLEN_W),
        .NUM_THR (NUM_THR)
    ) u_hlen_regfile (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (hlen_wr_en),
        .wr_thread (hlen_wr_thread),
        .wr_data   (hlen_wr_data),
        .rd_thread (in_thread),
        .rd_data_c (hlen_c)
    );

    // A free or draining output register can take a new op.
    assign in_ready = !out_valid_q || out_ready;

    // Operand datapath: HLEN words scaled to bytes, added modulo 2^DATA_W.
    always_comb begin
        mem_c        = in_lw | in_sw;
        accept_c     = in_valid & in_ready;
        hlen_bytes_c = DATA_W'(hlen_c) << HLEN_SHIFT;
        operand_c    = mem_c ? (in_offset + hlen_bytes_c) : in_offset;
        oob_c        = mem_c && (operand_c >= MEM_LIMIT);
    end

    // Output stage control: flush beats accept; a held result clears once taken.
    always_comb begin
        out_valid_d   = out_valid_q;
        out_operand_d = out_operand_q;
        out_is_mem_d  = out_is_mem_q;
        out_oob_d     = out_oob_q;
        cnt_d         = cnt_q;

        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept_c) begin
            out_valid_d   = 1'b1;
            out_operand_d = operand_c;
            out_is_mem_d  = mem_c;
            out_oob_d     = oob_c;
            if (mem_c && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output register and counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q   <= 1'b0;
            out_operand_q <= '0;
            out_is_mem_q  <= 1'b0;
            out_oob_q     <= 1'b0;
            cnt_q         <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_operand_q <= out_operand_d;
            out_is_mem_q  <= out_is_mem_d;
            out_oob_q     <= out_oob_d;
            cnt_q         <= cnt_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_operand  = out_operand_q;
    assign out_is_mem   = out_is_mem_q;
    assign out_oob      = out_oob_q;
    assign mem_op_count = cnt_q;

endmodule

// File: tb/tb_ea_offset_pipe.sv
// Scoreboard bench for ea_offset_pipe: a default instance plus a CNT_W=2 instance
// sharing the same stimulus. Expected results come from a plain arithmetic model.
module tb_ea_offset_pipe;

    localparam int unsigned NUM_THR = 4;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_lw, in_sw, hlen_wr_en, out_ready;
    logic [1:0]  in_thread, hlen_wr_thread;
    logic [63:0] in_offset;
    logic [7:0]  hlen_wr_data;

    logic        in_ready_a, out_valid_a, out_is_mem_a, out_oob_a;
    logic [63:0] out_operand_a;
    logic [15:0] cnt_a;
    logic        in_ready_b, out_valid_b, out_is_mem_b, out_oob_b;
    logic [63:0] out_operand_b;
    logic [1:0]  cnt_b;

    always #5 clk = ~clk;

    ea_offset_pipe u_dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_thread(in_thread),
        .in_lw(in_lw), .in_sw(in_sw), .in_offset(in_offset),
        .hlen_wr_en(hlen_wr_en), .hlen_wr_thread(hlen_wr_thread), .hlen_wr_data(hlen_wr_data),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_operand(out_operand_a),
        .out_is_mem(out_is_mem_a), .out_oob(out_oob_a), .mem_op_count(cnt_a)
    );

    ea_offset_pipe #(.CNT_W(2)) u_dut_small (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_thread(in_thread),
        .in_lw(in_lw), .in_sw(in_sw), .in_offset(in_offset),
        .hlen_wr_en(hlen_wr_en), .hlen_wr_thread(hlen_wr_thread), .hlen_wr_data(hlen_wr_data),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_operand(out_operand_b),
        .out_is_mem(out_is_mem_b), .out_oob(out_oob_b), .mem_op_count(cnt_b)
    );

    typedef struct {
        logic [63:0] operand;
        logic        is_mem;
        logic        oob;
    } exp_t;

    exp_t        sb[$];
    int unsigned hlen_m [NUM_THR];
    int unsigned exp_cnt;
    int          checks;
    int          failures;
    bit          mon_en;
    bit          acc;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Inputs are set at a falling edge; model bookkeeping runs just before the rising edge.
    task automatic tick(output bit accepted);
        bit          mem;
        int unsigned hl;
        logic [63:0] e;
        #4;
        accepted = 1'b0;
        if (reset) begin
            sb.delete();
            for (int t = 0; t < NUM_THR; t++) hlen_m[t] = 0;
            exp_cnt = 0;
        end else begin
            mem = in_lw | in_sw;
            hl  = (hlen_wr_en && (hlen_wr_thread == in_thread)) ? int'(hlen_wr_data)
                                                                : hlen_m[in_thread];
            accepted = in_valid && (sb.size() == 0);
            if (flush) begin
                sb.delete();
            end else if (accepted) begin
                e = in_offset + (mem ? 64'(hl) * 64'd8 : 64'd0);
                sb.push_back('{operand: e, is_mem: mem, oob: mem && (e >= 64'd2048)});
                if (mem && exp_cnt < 65535) exp_cnt++;
            end
            if (hlen_wr_en) hlen_m[hlen_wr_thread] = int'(hlen_wr_data);
        end
        @(negedge clk);
    endtask

    task automatic set_idle();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_lw = 1'b0; in_sw = 1'b0;
        in_thread = '0; in_offset = '0; hlen_wr_en = 1'b0; hlen_wr_thread = '0;
        hlen_wr_data = '0; out_ready = 1'b1;
    endtask

    task automatic set_op(input int thr, input bit lw, input bit sw, input logic [63:0] off);
        in_valid = 1'b1; in_thread = 2'(thr); in_lw = lw; in_sw = sw; in_offset = off;
    endtask

    // Present one op until it is taken, bounded.
    task automatic send(input int thr, input bit lw, input bit sw, input logic [63:0] off);
        bit done = 1'b0;
        set_op(thr, lw, sw, off);
        for (int k = 0; k < 50 && !done; k++) tick(done);
        if (!done) chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic wr(input int thr, input int data);
        hlen_wr_en = 1'b1; hlen_wr_thread = 2'(thr); hlen_wr_data = 8'(data);
        tick(acc);
        hlen_wr_en = 1'b0;
    endtask

    // Monitor: compares both instances against the scoreboard head every cycle.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (mon_en) begin
                chk("out_valid_a", 64'(out_valid_a), 64'(sb.size() != 0));
                chk("out_valid_b", 64'(out_valid_b), 64'(sb.size() != 0));
                chk("in_ready_a", 64'(in_ready_a), 64'((sb.size() == 0) || out_ready));
                chk("in_ready_b", 64'(in_ready_b), 64'((sb.size() == 0) || out_ready));
                chk("count_a", 64'(cnt_a), 64'(exp_cnt));
                chk("count_b_sat", 64'(cnt_b), 64'((exp_cnt > 3) ? 3 : exp_cnt));
                if (sb.size() != 0) begin
                    chk("operand_a", out_operand_a, sb[0].operand);
                    chk("is_mem_a", 64'(out_is_mem_a), 64'(sb[0].is_mem));
                    chk("oob_a", 64'(out_oob_a), 64'(sb[0].oob));
                    chk("operand_b", out_operand_b, sb[0].operand);
                    if (out_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0; mon_en = 1'b0; exp_cnt = 0;
        set_idle();
        reset = 1'b1;
        @(negedge clk);
        tick(acc);
        tick(acc);
        reset = 1'b0;

        chk("rst_out_valid", 64'(out_valid_a), 64'd0);
        chk("rst_operand", out_operand_a, 64'd0);
        chk("rst_is_mem", 64'(out_is_mem_a), 64'd0);
        chk("rst_oob", 64'(out_oob_a), 64'd0);
        chk("rst_count", 64'(cnt_a), 64'd0);
        chk("rst_in_ready", 64'(in_ready_a), 64'd1);
        mon_en = 1'b1;

        // Basic select and HLEN adjustment.
        send(0, 1, 0, 64'd7);
        wr(2, 5);
        send(2, 0, 1, 64'd8);
        send(1, 0, 1, 64'd8);
        send(2, 0, 0, 64'd9);
        send(2, 1, 1, 64'd10);

        // Same-cycle bypass, and a write to another thread alongside a read.
        hlen_wr_en = 1'b1; hlen_wr_thread = 2'd3; hlen_wr_data = 8'd2;
        send(3, 1, 0, 64'd0);
        hlen_wr_thread = 2'd1; hlen_wr_data = 8'd9;
        send(2, 1, 0, 64'd0);
        hlen_wr_en = 1'b0;

        // Out-of-range boundary and modular wrap.
        wr(3, 255);
        send(3, 1, 0, 64'd0);
        send(3, 1, 0, 64'd8);
        send(3, 0, 1, 64'hFFFF_FFFF_FFFF_FFF8);
        send(3, 0, 0, 64'hFFFF_FFFF_FFFF_FFF0);
        send(1, 1, 0, 64'd0);
        tick(acc);

        // Stall with a second op waiting.
        out_ready = 1'b0;
        send(0, 1, 0, 64'd100);
        set_op(0, 0, 1, 64'd200);
        for (int k = 0; k < 3; k++) tick(acc);
        out_ready = 1'b1;
        tick(acc);
        in_valid = 1'b0;
        tick(acc);
        tick(acc);

        // Flush during a stall, with an HLEN write that must still land.
        out_ready = 1'b0;
        send(1, 1, 0, 64'd5);
        set_op(2, 1, 0, 64'd6);
        flush = 1'b1;
        hlen_wr_en = 1'b1; hlen_wr_thread = 2'd0; hlen_wr_data = 8'd3;
        tick(acc);
        flush = 1'b0; in_valid = 1'b0; hlen_wr_en = 1'b0;
        tick(acc);
        tick(acc);
        out_ready = 1'b1;
        send(0, 1, 0, 64'd1);
        tick(acc);

        // Reset while stalled, then saturation of the narrow counter.
        out_ready = 1'b0;
        send(2, 1, 0, 64'd1);
        reset = 1'b1;
        tick(acc);
        reset = 1'b0;
        tick(acc);
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) send(k % 4, 1, 0, 64'(k));
        tick(acc);
        tick(acc);

        // Randomised traffic.
        for (int i = 0; i < 800; i++) begin
            in_valid       = ($urandom_range(0, 3) != 0);
            in_thread      = 2'($urandom_range(0, 3));
            in_lw          = 1'($urandom_range(0, 1));
            in_sw          = 1'($urandom_range(0, 1));
            in_offset      = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom}
                                                         : 64'($urandom_range(0, 2100));
            hlen_wr_en     = ($urandom_range(0, 3) == 0);
            hlen_wr_thread = 2'($urandom_range(0, 3));
            hlen_wr_data   = 8'($urandom);
            out_ready      = ($urandom_range(0, 3) != 0);
            flush          = ($urandom_range(0, 19) == 0);
            tick(acc);
        end

        set_idle();
        tick(acc);
        tick(acc);
        tick(acc);
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
